// File: rtl/fma_norm_sched_pkg.sv
// rtl/fma_norm_sched_pkg.sv - shared constants and state type for the FMAdd normalization scheduler
//
// Purpose: widths shared by the scheduler and its leading-zero anticipator.
//   SIG_WIDTH/EXP_WIDTH : stored significand / exponent bits
//   M, DW               : full significand width and operand/sum/shifter width
//   EW                  : signed internal exponent width
//   SHAMT_W             : normalization shift-count width
package fma_pkg;

  localparam int SIG_WIDTH = 23;
  localparam int EXP_WIDTH = 8;
  localparam int M         = SIG_WIDTH + 1;
  localparam int DW        = 2 * M + 2;
  localparam int EW        = EXP_WIDTH + 2;
  localparam int SHAMT_W   = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ANTIC,
    S_SHIFT,
    S_CORR,
    S_OUT
  } norm_state_t;

endpackage

// File: rtl/fma_norm_sched_lza.sv
// rtl/fma_norm_sched_lza.sv - leading-zero anticipator for an unsigned two-operand add
//
// Purpose: predicts the normalization shift of opA+opB from the operands alone,
//   so it can run in parallel with the adder. Never overshoots; may be one short.
// Ports:
//   opA, opB : addends (DW bits)
//   ldCount  : anticipated leading-zero count of the sum
module lza
  import fma_pkg::*;
(
  input  logic [DW-1:0]      opA,
  input  logic [DW-1:0]      opB,
  output logic [SHAMT_W-1:0] ldCount
);

  localparam logic [SHAMT_W-1:0] ONE = 1;

  logic [DW-1:0]      any_one;
  logic               found;
  logic [SHAMT_W-1:0] lz;

  // The sum's leading one sits at the leading one of (opA|opB) or one above it,
  // so clz(opA|opB)-1 is a safe estimate that is at most one short.
  always_comb begin
    any_one = opA | opB;
    found   = 1'b0;
    lz      = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (!found) begin
        if (any_one[i]) begin
          found = 1'b1;
        end else begin
          lz = lz + ONE;
        end
      end
    end
    ldCount = (lz == '0) ? '0 : lz - ONE;
  end

endmodule

// File: rtl/fma_norm_sched.sv
// rtl/fma_norm_sched.sv - two-requester normalization scheduler sharing one LZA and shifter
//
// Purpose: round-robin arbitrates the add and FMA paths onto one adder, LZA and
//   normalizing shifter; sequences IDLE -> ANTIC -> SHIFT -> CORR -> OUT.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   reqN_valid/ready/opa/opb/exp      : requester N handshake and operands
//   out_valid/out_ready               : result handshake
//   out_sig, out_exp, out_src         : normalized sum, adjusted exponent, requester index
//   out_zero, out_corr                : sum was zero, one-bit correction applied
module fma_norm_sched
  import fma_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_opa,
  input  logic [DW-1:0]   req0_opb,
  input  logic [EW-1:0]   req0_exp,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_opa,
  input  logic [DW-1:0]   req1_opb,
  input  logic [EW-1:0]   req1_exp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_sig,
  output logic [EW-1:0]   out_exp,
  output logic            out_src,
  output logic            out_zero,
  output logic            out_corr
);

  localparam logic [EW-1:0] EXP_ONE = 1;

  norm_state_t        state_q, state_d;
  logic               last_q, last_d;
  logic [DW-1:0]      opa_q, opa_d;
  logic [DW-1:0]      opb_q, opb_d;
  logic [EW-1:0]      exp_q, exp_d;
  logic               src_q, src_d;
  logic [DW-1:0]      sum_q, sum_d;
  logic [SHAMT_W-1:0] ld_q, ld_d;
  logic [DW-1:0]      sig_q, sig_d;
  logic               zero_q, zero_d;
  logic               corr_q, corr_d;
  logic               out_valid_q, out_valid_d;

  logic [SHAMT_W-1:0] ld_cnt;
  logic               grant0;
  logic               grant1;

  // Anticipator reads the captured operands, in parallel with the ANTIC adder.
  lza u_lza (
    .opA     (opa_q),
    .opB     (opb_q),
    .ldCount (ld_cnt)
  );

  // On a tie, grant the requester that was not served last.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    exp_d       = exp_q;
    src_d       = src_q;
    sum_d       = sum_q;
    ld_d        = ld_q;
    sig_d       = sig_q;
    zero_d      = zero_q;
    corr_d      = corr_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          src_d   = grant1;
          last_d  = grant1;
          opa_d   = grant1 ? req1_opa : req0_opa;
          opb_d   = grant1 ? req1_opb : req0_opb;
          exp_d   = grant1 ? req1_exp : req0_exp;
          state_d = S_ANTIC;
        end
      end
      S_ANTIC: begin
        sum_d   = opa_q + opb_q;  // carry-out intentionally dropped
        ld_d    = ld_cnt;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sig_d   = sum_q << ld_q;
        exp_d   = exp_q - {{(EW - SHAMT_W){1'b0}}, ld_q};
        state_d = S_CORR;
      end
      S_CORR: begin
        if (sig_q == '0) begin
          zero_d = 1'b1;
          exp_d  = '0;
        end else if (!sig_q[DW-1]) begin
          // Anticipator came up one short.
          sig_d  = sig_q << 1;
          exp_d  = exp_q - EXP_ONE;
          corr_d = 1'b1;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          corr_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      opa_q       <= '0;
      opb_q       <= '0;
      exp_q       <= '0;
      src_q       <= 1'b0;
      sum_q       <= '0;
      ld_q        <= '0;
      sig_q       <= '0;
      zero_q      <= 1'b0;
      corr_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      exp_q       <= exp_d;
      src_q       <= src_d;
      sum_q       <= sum_d;
      ld_q        <= ld_d;
      sig_q       <= sig_d;
      zero_q      <= zero_d;
      corr_q      <= corr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sig   = sig_q;
  assign out_exp   = exp_q;
  assign out_src   = src_q;
  assign out_zero  = zero_q;
  assign out_corr  = corr_q;

endmodule
